// File: rtl/m_wb_uart_pkg.sv
// m_wb_uart shared definitions: register offsets,
// status bit indices and engine state encodings.
package m_wb_uart_pkg;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STAT = 1'b1;

  localparam int ST_TXFULL = 0;
  localparam int ST_TXIDLE = 1;
  localparam int ST_RXNE   = 2;
  localparam int ST_OVR    = 3;
  localparam int ST_FERR   = 4;
  localparam int ST_LOOP   = 5;

  localparam int DAT_RXNE  = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/m_wb_uart_if.sv
// m_wb_uart Wishbone slave bus bundle,
// zero-wait-state, ACK follows STB.
interface m_wb_uart_if;
  logic        STB_I;
  logic        WE_I;
  logic        ADR_I;
  logic [3:0]  SEL_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport master (
    output STB_I, WE_I, ADR_I, SEL_I, DAT_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  STB_I, WE_I, ADR_I, SEL_I, DAT_I,
    output DAT_O, ACK_O
  );
endinterface

// File: rtl/m_wb_uart_fifo.sv
// m_wb_uart byte FIFO: power-of-two depth,
// push while full succeeds only with a pop.
module m_wb_uart_fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG2DEPTH = 2
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int DEPTH = 2**LOG2DEPTH;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG2DEPTH-1:0] wp;
  logic [LOG2DEPTH-1:0] rp;
  logic [LOG2DEPTH:0]   cnt;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (LOG2DEPTH+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rp];

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + LOG2DEPTH'(1);
      if (do_pop)  rp <= rp + LOG2DEPTH'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (LOG2DEPTH+1)'(1);
        2'b01:   cnt <= cnt - (LOG2DEPTH+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/m_wb_uart.sv
// m_wb_uart: 8N1 Wishbone UART with TX/RX FIFOs.
// Define M_WB_UART_LOOPBACK_EN for internal TX->RX loopback.
module m_wb_uart
  import m_wb_uart_pkg::*;
#(
  parameter int DIVWIDTH = 16,
  parameter int DIVRESET = 104,
  parameter int FIFOLOG2 = 2
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  m_wb_uart_if.slave   wb,
  input  logic         usartRX,
  output logic         usartTX,
  output logic         irq
);
  logic [DIVWIDTH-1:0] div_q, period, half, reload;
  logic [15:0] div16;
  logic rd0, wr0, wr1;
  logic tx_full, tx_empty, tx_pop;
  logic rx_full, rx_empty, rx_push;
  logic [7:0] tx_head, rx_head;
  logic ovr_q, fe_q, ovr_set, fe_set;
  logic loop_q, rx_in;
  logic unused;

  assign period = (div_q < DIVWIDTH'(2)) ? DIVWIDTH'(2) : div_q;
  assign half   = period >> 1;
  assign reload = period - DIVWIDTH'(1);
  assign div16  = 16'(div_q);

  assign rd0 = wb.STB_I & ~wb.WE_I & (wb.ADR_I == REG_DATA);
  assign wr0 = wb.STB_I & wb.WE_I & (wb.ADR_I == REG_DATA)
             & wb.SEL_I[0];
  assign wr1 = wb.STB_I & wb.WE_I & (wb.ADR_I == REG_STAT);
  assign wb.ACK_O = wb.STB_I;
  assign unused = &{1'b0, wb.DAT_I[15:8], wb.DAT_I[1],
                    wb.SEL_I[1]};

  m_wb_uart_fifo #(.WIDTH(8), .LOG2DEPTH(FIFOLOG2)) u_txf (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .push(wr0), .pop(tx_pop), .din(wb.DAT_I[7:0]),
    .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  // ------------------------------------------------------------ TX
  tx_state_t tx_st, tx_nx;
  logic [DIVWIDTH-1:0] tx_cnt, tx_cnt_nx;
  logic [7:0] tx_sh, tx_sh_nx;
  logic [2:0] tx_bit, tx_bit_nx;
  logic tx_zero;

  assign tx_zero = (tx_cnt == '0);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_sh  <= '0;
      tx_bit <= '0;
    end else begin
      tx_st  <= tx_nx;
      tx_cnt <= tx_cnt_nx;
      tx_sh  <= tx_sh_nx;
      tx_bit <= tx_bit_nx;
    end
  end

  always_comb begin
    tx_nx     = tx_st;
    tx_cnt_nx = tx_zero ? tx_cnt : tx_cnt - DIVWIDTH'(1);
    tx_sh_nx  = tx_sh;
    tx_bit_nx = tx_bit;
    tx_pop    = 1'b0;
    unique case (tx_st)
      TX_IDLE: if (!tx_empty) begin
        tx_nx     = TX_START;
        tx_pop    = 1'b1;
        tx_sh_nx  = tx_head;
        tx_cnt_nx = reload;
      end
      TX_START: if (tx_zero) begin
        tx_nx     = TX_DATA;
        tx_bit_nx = '0;
        tx_cnt_nx = reload;
      end
      TX_DATA: if (tx_zero) begin
        tx_sh_nx  = {1'b0, tx_sh[7:1]};
        tx_bit_nx = tx_bit + 3'd1;
        tx_cnt_nx = reload;
        if (tx_bit == 3'd7) tx_nx = TX_STOP;
      end
      TX_STOP: if (tx_zero) begin
        // next byte chains straight into its start bit
        if (!tx_empty) begin
          tx_nx     = TX_START;
          tx_pop    = 1'b1;
          tx_sh_nx  = tx_head;
          tx_cnt_nx = reload;
        end else begin
          tx_nx = TX_IDLE;
        end
      end
      default: tx_nx = TX_IDLE;
    endcase
  end

  always_comb begin
    unique case (tx_st)
      TX_START: usartTX = 1'b0;
      TX_DATA:  usartTX = tx_sh[0];
      default:  usartTX = 1'b1;
    endcase
  end

  // ------------------------------------------------------------ RX
`ifdef M_WB_UART_LOOPBACK_EN
  always_ff @(posedge CLK_I) begin
    if (RST_I)                loop_q <= 1'b0;
    else if (wr1 & wb.SEL_I[0]) loop_q <= wb.DAT_I[1];
  end
  assign rx_in = loop_q ? usartTX : usartRX;
`else
  assign loop_q = 1'b0;
  assign rx_in  = usartRX;
`endif

  rx_state_t rx_st, rx_nx;
  logic [DIVWIDTH-1:0] rx_cnt, rx_cnt_nx;
  logic [7:0] rx_sh, rx_sh_nx;
  logic [2:0] rx_bit, rx_bit_nx;
  logic rx_meta, rxs, rxs_d, rx_zero;

  assign rx_zero = (rx_cnt == '0);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_sh   <= '0;
      rx_bit  <= '0;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
      rx_st   <= rx_nx;
      rx_cnt  <= rx_cnt_nx;
      rx_sh   <= rx_sh_nx;
      rx_bit  <= rx_bit_nx;
    end
  end

  always_comb begin
    rx_nx     = rx_st;
    rx_cnt_nx = rx_zero ? rx_cnt : rx_cnt - DIVWIDTH'(1);
    rx_sh_nx  = rx_sh;
    rx_bit_nx = rx_bit;
    rx_push   = 1'b0;
    ovr_set   = 1'b0;
    fe_set    = 1'b0;
    unique case (rx_st)
      RX_IDLE: if (rxs_d & ~rxs) begin
        rx_nx     = RX_START;
        rx_cnt_nx = half - DIVWIDTH'(1);
      end
      RX_START: if (rx_zero) begin
        if (rxs) begin
          rx_nx = RX_IDLE;
        end else begin
          rx_nx     = RX_DATA;
          rx_bit_nx = '0;
          rx_cnt_nx = reload;
        end
      end
      RX_DATA: if (rx_zero) begin
        rx_sh_nx  = {rxs, rx_sh[7:1]};
        rx_bit_nx = rx_bit + 3'd1;
        rx_cnt_nx = reload;
        if (rx_bit == 3'd7) rx_nx = RX_STOP;
      end
      RX_STOP: if (rx_zero) begin
        rx_nx = RX_IDLE;
        // a same-cycle read frees the slot for this byte
        if (!rxs)                 fe_set  = 1'b1;
        else if (rx_full & ~rd0)  ovr_set = 1'b1;
        else                      rx_push = 1'b1;
      end
      default: rx_nx = RX_IDLE;
    endcase
  end

  m_wb_uart_fifo #(.WIDTH(8), .LOG2DEPTH(FIFOLOG2)) u_rxf (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .push(rx_push), .pop(rd0), .din(rx_sh),
    .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  // ------------------------------------------------------ registers
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      div_q <= DIVWIDTH'(DIVRESET);
      ovr_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      if (wr1 & (wb.SEL_I[2] | wb.SEL_I[3]))
        div_q <= wb.DAT_I[16 +: DIVWIDTH];
      if (wr1 & wb.SEL_I[0] & wb.DAT_I[0]) begin
        ovr_q <= 1'b0;
        fe_q  <= 1'b0;
      end
      if (ovr_set) ovr_q <= 1'b1;
      if (fe_set)  fe_q  <= 1'b1;
    end
  end

  assign irq = ~rx_empty | ovr_q | fe_q;

  always_comb begin
    wb.DAT_O = '0;
    if (wb.STB_I) begin
      if (wb.ADR_I == REG_DATA) begin
        if (!rx_empty) begin
          wb.DAT_O[7:0]     = rx_head;
          wb.DAT_O[DAT_RXNE] = 1'b1;
        end
      end else begin
        wb.DAT_O[31:16]     = div16;
        wb.DAT_O[ST_TXFULL] = tx_full;
        wb.DAT_O[ST_TXIDLE] = tx_empty & (tx_st == TX_IDLE);
        wb.DAT_O[ST_RXNE]   = ~rx_empty;
        wb.DAT_O[ST_OVR]    = ovr_q;
        wb.DAT_O[ST_FERR]   = fe_q;
        wb.DAT_O[ST_LOOP]   = loop_q;
      end
    end
  end
endmodule
